// File: rtl/piso_serializer_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out LSB first, holding each bit for CLKS_PER_BIT cycles.
// Every output is decoded from registered state only.
module piso_serializer_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             LOAD_READY,
  output logic             SO,
  output logic             SO_VALID,
  output logic             BIT_STB,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;

  logic div_last;
  logic bit_last;

  assign div_last = (div_cnt_q == DivW'(CLKS_PER_BIT - 1));
  assign bit_last = (bit_cnt_q == CntW'(WIDTH - 1));

  // Next-state: load in idle, count bit periods while shifting, one-cycle done.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      StIdle: begin
        if (LOAD_VALID) begin
          shreg_d   = DATA_IN;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (bit_last) begin
            state_d = StDone;
          end else begin
            shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset mid-frame discards the word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign LOAD_READY = (state_q == StIdle);
  assign SO_VALID   = (state_q == StShift);
  assign SO         = (state_q == StShift) & shreg_q[0];
  assign BIT_STB    = (state_q == StShift) & div_last;
  assign BUSY       = (state_q == StShift) | (state_q == StDone);
  assign DONE       = (state_q == StDone);

endmodule

// File: tb/tb_piso_serializer_tx.sv
// Bench for piso_serializer_tx: two instances (CLKS_PER_BIT 1 and 4) share inputs.
// A frame-position model predicts every output each cycle; loopback SIPOs rebuild words.
module tb_piso_serializer_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD_VALID;
  logic [7:0] DATA_IN;

  logic rdy1, so1, sov1, stb1, busy1, done1;
  logic rdy2, so2, sov2, stb2, busy2, done2;

  piso_serializer_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .DATA_IN(DATA_IN),
    .LOAD_READY(rdy1), .SO(so1), .SO_VALID(sov1), .BIT_STB(stb1), .BUSY(busy1), .DONE(done1)
  );

  piso_serializer_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut2 (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .DATA_IN(DATA_IN),
    .LOAD_READY(rdy2), .SO(so2), .SO_VALID(sov2), .BIT_STB(stb2), .BUSY(busy2), .DONE(done2)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: p = position in frame (0 idle, 1..N bit cycles, N+1 done).
  int         p1 = 0, p2 = 0;
  logic [7:0] d1, d2;
  logic       chk_en = 1'b0;

  function automatic int next_p(input int p, input int n, input logic rst, input logic lv);
    if (rst) return 0;
    if (p == 0) return lv ? 1 : 0;
    if (p == n + 1) return 0;
    return p + 1;
  endfunction

  // {SO, SO_VALID, BIT_STB, BUSY, DONE, LOAD_READY}
  function automatic logic [5:0] expv(input int p, input logic [7:0] d, input int cpb);
    int   n;
    logic sov, so, stb;
    n   = 8 * cpb;
    sov = (p >= 1) && (p <= n);
    so  = sov ? d[(p - 1) / cpb] : 1'b0;
    stb = sov && (((p - 1) % cpb) == cpb - 1);
    return {so, sov, stb, p >= 1, p == n + 1, p == 0};
  endfunction

  always @(posedge CLK) begin
    p1 <= next_p(p1, 8, RST, LOAD_VALID);
    p2 <= next_p(p2, 32, RST, LOAD_VALID);
    if (!RST && p1 == 0 && LOAD_VALID) d1 <= DATA_IN;
    if (!RST && p2 == 0 && LOAD_VALID) d2 <= DATA_IN;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_cpb1", {so1, sov1, stb1, busy1, done1, rdy1}, expv(p1, d1, 1));
      check("model_cpb4", {so2, sov2, stb2, busy2, done2, rdy2}, expv(p2, d2, 4));
    end
  end

  // Loopback SIPOs shifting toward bit 0 on each strobe; word captured at DONE.
  logic [7:0] sipo1 = '0, sipo2 = '0;
  logic [7:0] rxq1[$], rxq2[$];

  always @(negedge CLK) begin
    if (stb1) sipo1 <= {so1, sipo1[7:1]};
    if (stb2) sipo2 <= {so2, sipo2[7:1]};
    if (done1) rxq1.push_back(sipo1);
    if (done2) rxq2.push_back(sipo2);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_rx(input string name, input int which, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (which == 1) begin
      if (rxq1.size() > 0) got = rxq1.pop_front();
    end else begin
      if (rxq2.size() > 0) got = rxq2.pop_front();
    end
    check(name, {24'd0, got}, {24'd0, exp});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (rdy1 && rdy2) break;
      tick();
    end
    check("wait_idle", {31'd0, rdy1 & rdy2}, 32'd1);
  endtask

  task automatic load(input logic [7:0] d);
    wait_idle();
    LOAD_VALID = 1'b1;
    DATA_IN    = d;
    tick();
    LOAD_VALID = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] data;
    logic [5:0] exp;  // {SO, SO_VALID, BIT_STB, BUSY, DONE, LOAD_READY}
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cnt_v, cnt_s, done_at, first_done, second_done, bad_rdy;
    logic [7:0] a5;

    RST        = 1'b1;
    LOAD_VALID = 1'b0;
    DATA_IN    = 8'h00;
    tick();
    chk_en = 1'b1;

    // Reset held with LOAD_VALID high, then A5 on the CLKS_PER_BIT=1 instance.
    a5 = 8'hA5;
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 6'b000001};
    vecs[1] = '{1'b1, 1'b1, 8'hA5, 6'b000001};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 6'b000001};
    for (int b = 0; b < 8; b++) vecs[3 + b] = '{1'b0, 1'b0, 8'h00, {a5[b], 5'b11100}};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 6'b000110};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 6'b000001};
    for (int i = 0; i < 13; i++) begin
      RST        = vecs[i].rst;
      LOAD_VALID = vecs[i].lv;
      DATA_IN    = vecs[i].data;
      check($sformatf("vec%0d", i), {26'd0, so1, sov1, stb1, busy1, done1, rdy1},
            {26'd0, vecs[i].exp});
      tick();
    end
    check_rx("loop_a5_cpb1", 1, 8'hA5);
    wait_idle();
    check_rx("loop_a5_cpb4", 2, 8'hA5);

    // 81 with each bit held 4 cycles.
    load(8'h81);
    cnt_v = 0; cnt_s = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (sov2) cnt_v++;
      if (stb2) cnt_s++;
      if (done2) done_at = c;
      tick();
    end
    check("cpb4_sov_cycles", cnt_v, 32);
    check("cpb4_stb_pulses", cnt_s, 8);
    check("cpb4_done_at", done_at, 33);
    check_rx("loop_81_cpb1", 1, 8'h81);
    check_rx("loop_81_cpb4", 2, 8'h81);

    // Loads attempted while busy are ignored.
    load(8'h0F);
    bad_rdy = 0;
    for (int c = 1; c <= 10; c++) begin
      LOAD_VALID = (c >= 3 && c <= 6);
      DATA_IN    = (c >= 3 && c <= 6) ? 8'hFF : 8'h00;
      if (c <= 9 && rdy1) bad_rdy++;
      tick();
    end
    LOAD_VALID = 1'b0;
    check("busy_ready_low", bad_rdy, 0);
    check_rx("loop_0f_cpb1", 1, 8'h0F);
    wait_idle();
    check_rx("loop_0f_cpb4", 2, 8'h0F);

    // Reset at bit 3 aborts; next frame is clean.
    load(8'h3C);
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_state", {26'd0, so1, sov1, stb1, busy1, done1, rdy1}, 32'b000001);
    for (int c = 0; c < 12; c++) tick();
    check("abort_no_done", rxq1.size() + rxq2.size(), 0);
    load(8'hC3);
    wait_idle();
    check_rx("loop_c3_cpb1", 1, 8'hC3);
    check_rx("loop_c3_cpb4", 2, 8'hC3);

    // LOAD_VALID held high: back-to-back frames separated by DONE plus one idle.
    wait_idle();
    LOAD_VALID = 1'b1;
    DATA_IN    = 8'h01;
    tick();
    DATA_IN = 8'h80;
    first_done = 0; second_done = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 11) LOAD_VALID = 1'b0;
      if (done1 && first_done == 0) first_done = c;
      else if (done1) second_done = c;
      tick();
    end
    check("b2b_first_done", first_done, 9);
    check("b2b_second_done", second_done, 19);
    check_rx("b2b_word0", 1, 8'h01);
    check_rx("b2b_word1", 1, 8'h80);
    wait_idle();
    check_rx("b2b_cpb4_word", 2, 8'h01);

    // Random loads, data and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      RST        = ($urandom_range(0, 59) == 0);
      LOAD_VALID = ($urandom_range(0, 2) == 0);
      DATA_IN    = 8'($urandom);
      tick();
    end
    RST        = 1'b0;
    LOAD_VALID = 1'b0;
    wait_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
